sobel_filter: RTL and testbench

Streaming 3x3 edge-detection stage that sits directly downstream of the greyscale converter. It consumes the 12-bit grey pixel stream (oGrey/oDVAL from the greyscale stage) and buffers two image rows internally. For each interior pixel it emits the centre pixel, |Gx|, |Gy| or |Gx|+|Gy|, according to a per-frame mode, feeding the display/SDRAM write path.

---
 rtl/sobel_pkg.sv | 26 ++
 rtl/sobel_line_buffer.sv | 29 ++
 rtl/sobel_filter.sv | 155 +++++++++++++++
 tb/tb_sobel_filter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming 3x3 Sobel edge stage.
package sobel_pkg;

  localparam int unsigned PIX_W   = 12;
  localparam int unsigned GRAD_W  = 16;
  localparam int unsigned POS_W   = 11;
  localparam int unsigned MAX_PIX = 4095;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GX   = 2'd1,
    MODE_GY   = 2'd2,
    MODE_SUM  = 2'd3
  } mode_e;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Magnitude of a signed gradient; |G| never exceeds 16380 so no overflow.
  function automatic logic [GRAD_W-1:0] abs_g(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? GRAD_W'($unsigned(-g)) : GRAD_W'($unsigned(g));
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line store: returns the two previous rows at addr, then shifts them
// down by one row (read-before-write at the same address).
module sobel_line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 12,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rd0_c,
  output logic [WIDTH-1:0] rd1_c
);

  logic [WIDTH-1:0] row0 [DEPTH];
  logic [WIDTH-1:0] row1 [DEPTH];

  assign rd0_c = row0[addr];
  assign rd1_c = row1[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      row1[addr] <= row0[addr];
      row0[addr] <= din;
    end
  end

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel stage: two-row line buffer, 3x3 window, per-frame mode,
// two-cycle pipeline from accepted pixel to output.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned DATA_W     = PIX_W
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [1:0]        iMODE,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [POS_W-1:0]  oX_Cont,
  output logic [POS_W-1:0]  oY_Cont
);

  localparam int unsigned AW = $clog2(IMG_WIDTH);

  logic [POS_W-1:0]  col, row;
  mode_e             mode_q;
  state_e            state, state_nxt;
  logic              run_c, accept_c, last_col_c, last_row_c;
  logic [DATA_W-1:0] lb0_c, lb1_c;
  logic [DATA_W-1:0] win [3][3];
  logic              v1;
  mode_e             m1;
  logic [POS_W-1:0]  x1, y1;
  logic signed [GRAD_W-1:0] gx_c, gy_c;
  logic [GRAD_W-1:0] abs_x_c, abs_y_c, mag_c;
  logic [DATA_W-1:0] pix_c;

  assign accept_c   = iDVAL & ~iRST;
  assign last_col_c = (col == POS_W'(IMG_WIDTH - 1));
  assign last_row_c = (row == POS_W'(IMG_HEIGHT - 1));

  sobel_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_W),
    .AW    (AW)
  ) u_line_buffer (
    .clk   (iCLK),
    .en    (accept_c),
    .addr  (AW'(col)),
    .din   (iDATA),
    .rd0_c (lb0_c),
    .rd1_c (lb1_c)
  );

  // Raster position and per-frame mode latched at the first pixel.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col    <= '0;
      row    <= '0;
      mode_q <= MODE_PASS;
    end else if (iDVAL) begin
      if (col == '0 && row == '0) mode_q <= mode_e'(iMODE);
      if (last_col_c) begin
        col <= '0;
        row <= last_row_c ? '0 : row + POS_W'(1);
      end else begin
        col <= col + POS_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (iDVAL && last_col_c && row == POS_W'(1)) state_nxt = RUN;
      RUN:     if (iDVAL && last_col_c && last_row_c)       state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    run_c = 1'b0;
    case (state)
      RUN:     run_c = 1'b1;
      default: run_c = 1'b0;
    endcase
  end

  // Stage 1: shift the window (column 2 / row 2 newest) and tag the centre.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      v1 <= 1'b0;
      m1 <= MODE_PASS;
      x1 <= '0;
      y1 <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      v1 <= iDVAL && run_c && (col >= POS_W'(2));
      if (iDVAL) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 2; c++)
            win[r][c] <= win[r][c+1];
        win[0][2] <= lb1_c;
        win[1][2] <= lb0_c;
        win[2][2] <= iDATA;
        m1 <= mode_q;
        x1 <= col - POS_W'(1);
        y1 <= row - POS_W'(1);
      end
    end
  end

  function automatic logic signed [GRAD_W-1:0] px(input logic [DATA_W-1:0] p);
    return $signed(GRAD_W'(p));
  endfunction

  always_comb begin
    gx_c = px(win[0][2]) + (px(win[1][2]) <<< 1) + px(win[2][2])
         - px(win[0][0]) - (px(win[1][0]) <<< 1) - px(win[2][0]);
    gy_c = px(win[2][0]) + (px(win[2][1]) <<< 1) + px(win[2][2])
         - px(win[0][0]) - (px(win[0][1]) <<< 1) - px(win[0][2]);
    abs_x_c = abs_g(gx_c);
    abs_y_c = abs_g(gy_c);
    case (m1)
      MODE_GX:  mag_c = abs_x_c;
      MODE_GY:  mag_c = abs_y_c;
      MODE_SUM: mag_c = abs_x_c + abs_y_c;
      default:  mag_c = GRAD_W'(win[1][1]);
    endcase
    pix_c = (mag_c > GRAD_W'(MAX_PIX)) ? DATA_W'(MAX_PIX) : DATA_W'(mag_c);
  end

  // Stage 2: saturated result and centre coordinates.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDATA   <= '0;
      oDVAL   <= 1'b0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
      oDVAL <= v1;
      if (v1) begin
        oDATA   <= pix_c;
        oX_Cont <= x1;
        oY_Cont <= y1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
// Scoreboard bench for sobel_filter on an 8x6 frame: the driver pushes expected
// outputs from an image-array reference model, a negedge monitor pops and compares.
module tb_sobel_filter;

  localparam int W = 8;
  localparam int H = 6;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [11:0] iDATA;
  logic        iDVAL;
  logic [1:0]  iMODE;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;

  sobel_filter #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_W     (12)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iDATA   (iDATA),
    .iDVAL   (iDVAL),
    .iMODE   (iMODE),
    .oDATA   (oDATA),
    .oDVAL   (oDVAL),
    .oX_Cont (oX_Cont),
    .oY_Cont (oY_Cont)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    int data;
    int x;
    int y;
    int due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   img[H][W];
  int   model_mode = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Output for newest pixel (r,c): centre (r-1,c-1), plain image arithmetic.
  function automatic int ref_pix(input int r, input int c, input int mode);
    int gx, gy, v;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    case (mode)
      0:       v = img[r-1][c-1];
      1:       v = iabs(gx);
      2:       v = iabs(gy);
      default: v = iabs(gx) + iabs(gy);
    endcase
    return (v > 4095) ? 4095 : v;
  endfunction

  function automatic int gen(input int kind, input int c);
    case (kind)
      0:       return 100;
      1:       return c * 10;
      2:       return (c < 4) ? 0 : 4095;
      3:       return int'($urandom_range(4095, 0));
      default: return int'($urandom_range(600, 0));
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oDVAL"}, int'(oDVAL), 0);
    check({tag, "_oDATA"}, int'(oDATA), 0);
    check({tag, "_oX_Cont"}, int'(oX_Cont), 0);
    check({tag, "_oY_Cont"}, int'(oY_Cont), 0);
  endtask

  task automatic drive_pixel(input int r, input int c, input int v, input int mode,
                             input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      iDVAL = 1'b0;
      iDATA = 12'($urandom);
      @(posedge iCLK); #1;
    end
    iDVAL = 1'b1;
    iDATA = 12'(v);
    iMODE = 2'(mode);
    if (r == 0 && c == 0) model_mode = mode;
    img[r][c] = v;
    if (r >= 2 && c >= 2) q.push_back('{ref_pix(r, c, model_mode), c - 1, r - 1, cyc + 2});
    @(posedge iCLK); #1;
    iDVAL = 1'b0;
  endtask

  // One-cycle reset right after the pixel just accepted; its output must vanish.
  task automatic pulse_reset();
    iRST  = 1'b1;
    iDVAL = 1'b0;
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    @(posedge iCLK); #1;
    iRST = 1'b0;
    check_reset_outputs("midrst");
  endtask

  task automatic send_frame(input int kind, input int mode_a, input int mode_b,
                            input int max_gap, input int rst_r, input int rst_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        drive_pixel(r, c, gen(kind, c), (r >= 3) ? mode_b : mode_a, max_gap);
        if (r == rst_r && c == rst_c) begin
          pulse_reset();
          return;
        end
      end
    end
  endtask

  always @(negedge iCLK) begin
    if (oDVAL === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got data=%0d x=%0d y=%0d at cycle %0d, expected no output",
                 oDATA, oX_Cont, oY_Cont, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (int'(oDATA) != e.data || int'(oX_Cont) != e.x || int'(oY_Cont) != e.y
            || cyc != e.due) begin
          errors++;
          $display("FAIL out: got data=%0d x=%0d y=%0d cyc=%0d expected data=%0d x=%0d y=%0d cyc=%0d",
                   oDATA, oX_Cont, oY_Cont, cyc, e.data, e.x, e.y, e.due);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int m;
    iRST  = 1'b1;
    iDVAL = 1'b0;
    iDATA = '0;
    iMODE = '0;
    repeat (3) @(posedge iCLK);
    #1;
    check_reset_outputs("reset");
    iRST = 1'b0;

    for (int k = 0; k < 4; k++) send_frame(0, k, k, 0, -1, -1);
    for (int k = 1; k < 4; k++) send_frame(1, k, k, 0, -1, -1);
    send_frame(2, 1, 1, 0, -1, -1);
    send_frame(1, 1, 1, 5, -1, -1);
    send_frame(1, 1, 2, 2, -1, -1);
    send_frame(1, 2, 2, 0, -1, -1);
    for (int k = 0; k < 3; k++) begin
      m = int'($urandom_range(3, 0));
      send_frame(4, m, 3 - m, 3, -1, -1);
    end
    send_frame(4, 3, 3, 1, 3, 5);
    send_frame(4, 3, 3, 1, -1, -1);
    send_frame(3, 1, 1, 2, -1, -1);
    send_frame(4, 0, 0, 0, -1, -1);

    iDVAL = 1'b0;
    repeat (10) @(posedge iCLK);
    #1;
    check("drain_pending", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
